// File: rtl/caption_renderer.sv
// caption_renderer: caption overlay producer. Tracks the pixel position from
// the video timing, reads characters from a double-buffered text RAM, fetches
// glyph rows from an external 8x8 font ROM and drives overlay_rgb/overlay_alpha.
// The overlay for an input pixel appears two cycles after it.
module caption_renderer #(
    parameter int unsigned H_ACTIVE = 240,
    parameter int unsigned V_ACTIVE = 160,
    parameter int unsigned COLS     = 30,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned BOX_Y    = 136
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vid_de_in,
    input  logic                            vid_hs_in,
    input  logic                            vid_vs_in,
    input  logic                            txt_we,
    input  logic [$clog2(COLS*ROWS)-1:0]    txt_addr,
    input  logic [7:0]                      txt_data,
    input  logic                            txt_commit,
    output logic                            txt_commit_pending,
    output logic [9:0]                      font_addr,
    input  logic [7:0]                      font_data,
    input  logic                            cfg_enable,
    input  logic                            cfg_bg_enable,
    input  logic [14:0]                     cfg_fg_rgb,
    input  logic [14:0]                     cfg_bg_rgb,
    output logic [14:0]                     overlay_rgb,
    output logic                            overlay_alpha
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = $clog2(CELLS);
    // Box limits, clamped to the active area
    localparam int unsigned X_LIM = (COLS * 8 < H_ACTIVE) ? COLS * 8 : H_ACTIVE;
    localparam int unsigned Y_END = (BOX_Y + ROWS * 8 < V_ACTIVE) ? BOX_Y + ROWS * 8 : V_ACTIVE;

    // Position tracking and control state
    logic [7:0] x_cnt_q, x_cnt_d;
    logic [7:0] y_cnt_q, y_cnt_d;
    logic       de_prev_q, de_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic       locked_q, locked_d;
    logic       front_q, front_d;
    logic       pending_q, pending_d;

    // Text banks; bit 7 of a character code is never stored
    logic [6:0] bank0_q [CELLS];
    logic [6:0] bank0_d [CELLS];
    logic [6:0] bank1_q [CELLS];
    logic [6:0] bank1_d [CELLS];

    // Pipeline stages 1 and 2
    logic [9:0] font_addr_q, font_addr_d;
    logic [2:0] s1_bit_sel_q, s1_bit_sel_d;
    logic       s1_in_box_q, s1_in_box_d;
    logic       s1_blank_q, s1_blank_d;
    logic [2:0] s2_bit_sel_q, s2_bit_sel_d;
    logic       s2_in_box_q, s2_in_box_d;
    logic       s2_blank_q, s2_blank_d;

    // Stage-0 intermediates
    logic        vs_rise;
    logic        de_fall;
    logic [7:0]  y_off;
    logic [15:0] cell_idx;
    logic        in_box;
    logic [6:0]  char_code;
    logic        wr_ok;
    logic        glyph;
    logic        unused_c;

    assign unused_c = ^{vid_hs_in, txt_data[7]};

    // Next-state logic: counters, lock, bank control, stage-0 lookup, pipeline
    always_comb begin
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        de_prev_d    = vid_de_in;
        vs_prev_d    = vid_vs_in;
        locked_d     = locked_q;
        front_d      = front_q;
        pending_d    = pending_q;
        bank0_d      = bank0_q;
        bank1_d      = bank1_q;
        font_addr_d  = font_addr_q;
        char_code    = 7'd0;

        vs_rise  = vid_vs_in & ~vs_prev_q;
        de_fall  = ~vid_de_in & de_prev_q;
        y_off    = y_cnt_q - 8'(BOX_Y);
        cell_idx = 16'(y_off[7:3]) * 16'(COLS) + 16'(x_cnt_q[7:3]);
        in_box   = vid_de_in & locked_q
                 & ({1'b0, x_cnt_q} < 9'(X_LIM))
                 & ({1'b0, y_cnt_q} >= 9'(BOX_Y))
                 & ({1'b0, y_cnt_q} < 9'(Y_END));

        // x restarts on every de=0 cycle, saturating
        if (!vid_de_in) begin
            x_cnt_d = 8'd0;
        end else if (x_cnt_q != 8'hFF) begin
            x_cnt_d = x_cnt_q + 8'd1;
        end

        // y clears on vs rise, counts de falling edges, saturating
        if (vs_rise) begin
            y_cnt_d = 8'd0;
        end else if (de_fall && (y_cnt_q != 8'hFF)) begin
            y_cnt_d = y_cnt_q + 8'd1;
        end

        if (vs_rise) begin
            locked_d = 1'b1;
        end

        // A commit coincident with vs rise swaps immediately
        if (vs_rise && (pending_q || txt_commit)) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
        end else if (txt_commit) begin
            pending_d = 1'b1;
        end

        // Writes land in the back bank as seen after this edge
        wr_ok = txt_we & (16'(txt_addr) < 16'(CELLS));
        if (wr_ok) begin
            if (front_d) begin
                bank0_d[txt_addr] = txt_data[6:0];
            end else begin
                bank1_d[txt_addr] = txt_data[6:0];
            end
        end

        if (cell_idx < 16'(CELLS)) begin
            char_code = front_q ? bank1_q[cell_idx[AW-1:0]] : bank0_q[cell_idx[AW-1:0]];
        end

        if (in_box) begin
            font_addr_d = {char_code, y_off[2:0]};
        end
        s1_bit_sel_d = x_cnt_q[2:0];
        s1_in_box_d  = in_box;
        s1_blank_d   = (char_code == 7'd0);
        s2_bit_sel_d = s1_bit_sel_q;
        s2_in_box_d  = s1_in_box_q;
        s2_blank_d   = s1_blank_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q      <= 8'd0;
            y_cnt_q      <= 8'd0;
            de_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            locked_q     <= 1'b0;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            font_addr_q  <= 10'd0;
            s1_bit_sel_q <= 3'd0;
            s1_in_box_q  <= 1'b0;
            s1_blank_q   <= 1'b0;
            s2_bit_sel_q <= 3'd0;
            s2_in_box_q  <= 1'b0;
            s2_blank_q   <= 1'b0;
            for (int i = 0; i < int'(CELLS); i++) begin
                bank0_q[i] <= 7'd0;
                bank1_q[i] <= 7'd0;
            end
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            de_prev_q    <= de_prev_d;
            vs_prev_q    <= vs_prev_d;
            locked_q     <= locked_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            font_addr_q  <= font_addr_d;
            s1_bit_sel_q <= s1_bit_sel_d;
            s1_in_box_q  <= s1_in_box_d;
            s1_blank_q   <= s1_blank_d;
            s2_bit_sel_q <= s2_bit_sel_d;
            s2_in_box_q  <= s2_in_box_d;
            s2_blank_q   <= s2_blank_d;
            bank0_q      <= bank0_d;
            bank1_q      <= bank1_d;
        end
    end

    // Stage-2 output mux, aligned with the font ROM read data
    always_comb begin
        overlay_alpha = 1'b0;
        overlay_rgb   = 15'd0;
        glyph         = ~s2_blank_q & font_data[3'd7 - s2_bit_sel_q];
        if (cfg_enable && s2_in_box_q) begin
            if (glyph) begin
                overlay_alpha = 1'b1;
                overlay_rgb   = cfg_fg_rgb;
            end else if (cfg_bg_enable) begin
                overlay_alpha = 1'b1;
                overlay_rgb   = cfg_bg_rgb;
            end
        end
    end

    assign font_addr          = font_addr_q;
    assign txt_commit_pending = pending_q;

endmodule

// File: tb/tb_caption_renderer.sv
// Directed testbench for caption_renderer with a small font ROM model.
module tb_caption_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  addr = 6'd0;
    logic [7:0]  data = 8'd0;
    logic        commit = 1'b0;
    logic        pending;
    logic [9:0]  font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        en = 1'b1;
    logic        bg_en = 1'b0;
    logic [14:0] fg = 15'h7FFF;
    logic [14:0] bg = 15'h001F;
    logic [14:0] rgb;
    logic        alpha;

    int total = 0;
    int bad = 0;
    logic [9:0]  fa_obs [256];
    logic [15:0] ov_obs [256];

    localparam logic [15:0] OV_FG  = {1'b1, 15'h7FFF};
    localparam logic [15:0] OV_BG  = {1'b1, 15'h001F};
    localparam logic [15:0] OV_OFF = 16'h0000;

    caption_renderer dut (
        .clk(clk), .rst(rst),
        .vid_de_in(de), .vid_hs_in(hs), .vid_vs_in(vs),
        .txt_we(we), .txt_addr(addr), .txt_data(data),
        .txt_commit(commit), .txt_commit_pending(pending),
        .font_addr(font_addr), .font_data(font_data),
        .cfg_enable(en), .cfg_bg_enable(bg_en),
        .cfg_fg_rgb(fg), .cfg_bg_rgb(bg),
        .overlay_rgb(rgb), .overlay_alpha(alpha)
    );

    always #5 clk = ~clk;

    // Font ROM: glyph row 7 is 0x01, every other row 0x80; one-cycle latency
    always @(posedge clk) font_data <= (font_addr[2:0] == 3'd7) ? 8'h01 : 8'h80;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [5:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; data = d;
        step();
        we = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        step();
        vs = 1'b0;
        step();
    endtask

    // One-pixel lines: each one advances y by one
    task automatic skip_lines(input int n);
        for (int k = 0; k < n; k++) begin
            de = 1'b1;
            step();
            de = 1'b0;
            step();
        end
    endtask

    // Drive an n-pixel line; record font_addr (t+1) and overlay (t+2) per pixel
    task automatic drive_line(input int n);
        for (int i = 0; i <= n; i++) begin
            de = (i < n);
            step();
            if (i < n) fa_obs[i] = font_addr;
            if (i >= 1) ov_obs[i-1] = {alpha, rgb};
        end
        de = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_alpha", 32'(alpha), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_font_addr", 32'(font_addr), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // Unlocked: nothing shown even inside the box with background on
        bg_en = 1'b1;
        skip_lines(136);
        drive_line(240);
        for (int x = 0; x < 240; x++) check($sformatf("unlocked_x%0d", x), 32'(ov_obs[x]), 32'(OV_OFF));
        bg_en = 1'b0;

        // Fill back bank, commit, swap at vs
        write_cell(6'd0, 8'h41);
        write_cell(6'd1, 8'hC1);
        write_cell(6'd2, 8'h80);
        write_cell(6'd30, 8'h23);
        check("pend_before_commit", 32'(pending), 32'd0);
        commit_pulse();
        check("pend_after_commit", 32'(pending), 32'd1);
        commit_pulse();
        check("pend_repeat_commit", 32'(pending), 32'd1);
        vs = 1'b1;
        step();
        check("pend_after_vs", 32'(pending), 32'd0);
        vs = 1'b0;
        step();

        // Line 136: glyph fetch
        skip_lines(136);
        drive_line(240);
        check("l136_fa_x0", 32'(fa_obs[0]), 32'h208);
        check("l136_ov_x0", 32'(ov_obs[0]), 32'(OV_FG));
        for (int x = 1; x < 8; x++) check($sformatf("l136_ov_x%0d", x), 32'(ov_obs[x]), 32'(OV_OFF));
        check("l136_fa_x8_bit7", 32'(fa_obs[8]), 32'h208);
        check("l136_ov_x8", 32'(ov_obs[8]), 32'(OV_FG));
        check("l136_fa_x16_blank", 32'(fa_obs[16]), 32'h000);
        check("l136_ov_x16_blank", 32'(ov_obs[16]), 32'(OV_OFF));
        check("l136_ov_x24", 32'(ov_obs[24]), 32'(OV_OFF));

        // Line 151: row 1, glyph row 7
        skip_lines(14);
        drive_line(8);
        check("l151_fa_x0", 32'(fa_obs[0]), 32'h11F);
        check("l151_ov_x0", 32'(ov_obs[0]), 32'(OV_OFF));
        check("l151_ov_x7", 32'(ov_obs[7]), 32'(OV_FG));
        step();
        step();
        check("fa_hold_idle", 32'(font_addr), 32'h11F);

        // Line 152: below the box
        drive_line(8);
        check("l152_fa_hold", 32'(fa_obs[0]), 32'h11F);
        check("l152_ov_x0", 32'(ov_obs[0]), 32'(OV_OFF));

        // Bank isolation: uncommitted write stays hidden
        write_cell(6'd0, 8'h42);
        vs_pulse();
        skip_lines(135);
        drive_line(8);
        check("l135_ov_x0", 32'(ov_obs[0]), 32'(OV_OFF));
        drive_line(8);
        check("iso_fa_old", 32'(fa_obs[0]), 32'h208);
        check("iso_ov_old", 32'(ov_obs[0]), 32'(OV_FG));
        commit_pulse();
        check("iso_pend_mid", 32'(pending), 32'd1);
        drive_line(8);
        check("iso_fa_l137_old", 32'(fa_obs[0]), 32'h209);
        vs = 1'b1;
        step();
        check("iso_pend_vs", 32'(pending), 32'd0);
        vs = 1'b0;
        step();
        skip_lines(136);
        drive_line(8);
        check("iso_fa_new", 32'(fa_obs[0]), 32'h210);

        // Commit and write coincident with vs rise
        vs = 1'b1; commit = 1'b1; we = 1'b1; addr = 6'd0; data = 8'h55;
        step();
        check("coinc_pend_edge", 32'(pending), 32'd0);
        vs = 1'b0; commit = 1'b0; we = 1'b0;
        step();
        check("coinc_pend_after", 32'(pending), 32'd0);
        skip_lines(136);
        drive_line(8);
        check("coinc_fa_swapped", 32'(fa_obs[0]), 32'h208);
        commit_pulse();
        vs_pulse();
        skip_lines(136);
        drive_line(8);
        check("swapcycle_write_fa", 32'(fa_obs[0]), 32'h2A8);

        // Background over an all-blank bank
        write_cell(6'd0, 8'h00);
        write_cell(6'd1, 8'h00);
        write_cell(6'd30, 8'h00);
        commit_pulse();
        vs_pulse();
        bg_en = 1'b1;
        skip_lines(136);
        for (int ln = 136; ln < 152; ln++) begin
            drive_line(240);
            for (int x = 0; x < 240; x++) check($sformatf("bg_l%0d_x%0d", ln, x), 32'(ov_obs[x]), 32'(OV_BG));
        end
        drive_line(240);
        check("bg_l152_x0", 32'(ov_obs[0]), 32'(OV_OFF));
        check("bg_l152_x239", 32'(ov_obs[239]), 32'(OV_OFF));

        // Disabled: nothing shown despite glyph and background
        en = 1'b0;
        commit_pulse();
        vs_pulse();
        skip_lines(136);
        drive_line(240);
        for (int x = 0; x < 240; x++) check($sformatf("dis_x%0d", x), 32'(ov_obs[x]), 32'(OV_OFF));

        // de toggling each cycle: every de=1 pixel is x=0 and shows 2 cycles later
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            de = ((i % 2) == 0);
            step();
            check($sformatf("toggle_%0d", i), 32'({alpha, rgb}),
                  32'(((i >= 1) && (((i - 1) % 2) == 0)) ? OV_FG : OV_OFF));
        end
        de = 1'b0;
        step();
        check("toggle_tail", 32'({alpha, rgb}), 32'(OV_OFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
